// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Shared definitions for the PIO program loader.
//   - PIO command action codes driven on the loader's action output.
//   - Loader FSM state encoding (also exported on the debug state port).
//   - range_ok(): validity check for a requested program placement.
// -----------------------------------------------------------------------------
package pio_pkg;

  // PIO command action codes
  localparam logic [3:0] ACT_NOP    = 4'd0;
  localparam logic [3:0] ACT_INSTR  = 4'd1;
  localparam logic [3:0] ACT_PEND   = 4'd2;
  localparam logic [3:0] ACT_PULL   = 4'd3;
  localparam logic [3:0] ACT_PUSH   = 4'd4;
  localparam logic [3:0] ACT_PINS   = 4'd5;
  localparam logic [3:0] ACT_EN     = 4'd6;
  localparam logic [3:0] ACT_DIV    = 4'd7;
  localparam logic [3:0] ACT_SIDE   = 4'd8;
  localparam logic [3:0] ACT_IMM    = 4'd9;
  localparam logic [3:0] ACT_JMPPIN = 4'd10;

  // Instruction memory depth of one PIO block
  localparam int IMEM_DEPTH = 32;

  // Loader FSM states. The order follows the command sequence emitted
  // after the program words have been written.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PEND = 3'd2,
    ST_PINS = 3'd3,
    ST_DIV  = 3'd4,
    ST_SIDE = 3'd5,
    ST_JMP  = 3'd6,
    ST_EN   = 3'd7
  } state_t;

  // A program is placeable when it is non-empty and its last word still
  // lands inside instruction memory. Evaluated at 7 bits so that the
  // largest addr + len cannot wrap.
  function automatic logic range_ok(input logic [4:0] addr, input logic [5:0] len);
    logic [6:0] w_end;
    w_end = {2'b00, addr} + {1'b0, len};
    return (len != 6'd0) && (w_end <= 7'(IMEM_DEPTH));
  endfunction

endpackage

// File: rtl/pio_loader.sv
// -----------------------------------------------------------------------------
// pio_loader
// Loads a program into a PIO state machine and configures it, or forwards
// single host commands when idle.
//
// A load is: one INSTR write per streamed word, then PEND (wrap index),
// PINS, DIV, SIDE, JMPPIN and finally EN, one command per cycle, followed by
// a one-cycle done pulse. All PIO command outputs are registered and return
// to zero in every cycle that carries no command.
//
// Handshake semantics (both the stream and the host port): a transfer happens
// in a cycle where valid and ready are both high at the rising clock edge;
// ready never depends on the transfer being accepted later, and valid may be
// held without ready for any number of cycles.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   start, abort           begin a load / synchronous cancel of a busy load
//   mach, start_addr,      target state machine, first instruction index,
//   prog_len               word count (1..32)
//   pins_cfg, div_cfg,     configuration words latched at start
//   side_cfg, jmp_cfg,
//   en_cfg
//   s_valid/s_data/s_ready instruction word stream (ready only in LOAD)
//   h_valid/h_action/      host command port (ready only when idle and no
//   h_index/h_mindex/      start is requested)
//   h_din/h_ready
//   action/index/mindex/   registered PIO command outputs
//   din
//   busy, done, err        status; done and err are one-cycle pulses
//   o_dbg_state            current FSM state, for observation only
// -----------------------------------------------------------------------------
module pio_loader
  import pio_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   mach,
  input  logic [4:0]   start_addr,
  input  logic [5:0]   prog_len,
  input  logic [31:0]  pins_cfg,
  input  logic [23:0]  div_cfg,
  input  logic [4:0]   side_cfg,
  input  logic [3:0]   jmp_cfg,
  input  logic [3:0]   en_cfg,
  input  logic         s_valid,
  input  logic [15:0]  s_data,
  output logic         s_ready,
  input  logic         h_valid,
  input  logic [3:0]   h_action,
  input  logic [4:0]   h_index,
  input  logic [1:0]   h_mindex,
  input  logic [31:0]  h_din,
  output logic         h_ready,
  output logic [3:0]   action,
  output logic [4:0]   index,
  output logic [1:0]   mindex,
  output logic [31:0]  din,
  output logic         busy,
  output logic         done,
  output logic         err,
  output state_t       o_dbg_state
);

  // The stall counter only has to reach TIMEOUT-1: the stall cycle that
  // finds it there is the TIMEOUT-th consecutive one.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  // State and latched load parameters
  state_t        r_state;
  logic [1:0]    r_mach;
  logic [4:0]    r_start_addr;
  logic [5:0]    r_prog_len;
  logic [31:0]   r_pins;
  logic [23:0]   r_div;
  logic [4:0]    r_side;
  logic [3:0]    r_jmp;
  logic [3:0]    r_en;

  // Progress counters
  logic [4:0]    r_addr;
  logic [5:0]    r_left;
  logic [TW-1:0] r_to_cnt;

  // Registered outputs
  logic [3:0]    r_action;
  logic [4:0]    r_index;
  logic [1:0]    r_mindex;
  logic [31:0]   r_din;
  logic          r_err;
  logic          r_done;
  logic          r_en_issued;

  // Next-cycle values from the combinational process
  state_t        w_state_nxt;
  logic [3:0]    w_action;
  logic [4:0]    w_index;
  logic [1:0]    w_mindex;
  logic [31:0]   w_din;
  logic          w_err;
  logic          w_en_issued;
  logic          w_latch;
  logic          w_word;
  logic          w_to_clr;
  logic          w_to_inc;
  logic          w_s_ready;
  logic          w_h_ready;
  logic [4:0]    w_last_idx;

  assign w_s_ready = (r_state == ST_LOAD);
  // Start wins over a host command offered in the same idle cycle.
  assign w_h_ready = ~reset & (r_state == ST_IDLE) & ~start;

  // Wrap index: the last instruction of the loaded program. The 5-bit sum
  // wraps correctly for prog_len=32 at start_addr=0 (index 31).
  assign w_last_idx = r_start_addr + r_prog_len[4:0] - 5'd1;

  // ---------------------------------------------------------------------------
  // Next-state and command selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_action    = ACT_NOP;
    w_index     = 5'd0;
    w_mindex    = 2'd0;
    w_din       = 32'd0;
    w_err       = 1'b0;
    w_en_issued = 1'b0;
    w_latch     = 1'b0;
    w_word      = 1'b0;
    w_to_clr    = 1'b0;
    w_to_inc    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (range_ok(start_addr, prog_len)) begin
            w_latch     = 1'b1;
            w_to_clr    = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_err = 1'b1;
          end
        end else if (h_valid && w_h_ready) begin
          w_action = h_action;
          w_index  = h_index;
          w_mindex = h_mindex;
          w_din    = h_din;
        end
      end

      ST_LOAD: begin
        // A word offered in the abort cycle is consumed by the handshake
        // but deliberately not written.
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (s_valid && w_s_ready) begin
          w_word   = 1'b1;
          w_to_clr = 1'b1;
          w_action = ACT_INSTR;
          w_index  = r_addr;
          w_mindex = r_mach;
          w_din    = {16'h0000, s_data};
          if (r_left == 6'd1) begin
            w_state_nxt = ST_PEND;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_to_inc = 1'b1;
        end
      end

      ST_PEND: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_action    = ACT_PEND;
          w_index     = w_last_idx;
          w_mindex    = r_mach;
          w_state_nxt = ST_PINS;
        end
      end

      ST_PINS: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_action    = ACT_PINS;
          w_mindex    = r_mach;
          w_din       = r_pins;
          w_state_nxt = ST_DIV;
        end
      end

      ST_DIV: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_action    = ACT_DIV;
          w_mindex    = r_mach;
          w_din       = {8'h00, r_div};
          w_state_nxt = ST_SIDE;
        end
      end

      ST_SIDE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_action    = ACT_SIDE;
          w_mindex    = r_mach;
          w_din       = {27'h0, r_side};
          w_state_nxt = ST_JMP;
        end
      end

      ST_JMP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_action    = ACT_JMPPIN;
          w_mindex    = r_mach;
          w_din       = {28'h0, r_jmp};
          w_state_nxt = ST_EN;
        end
      end

      ST_EN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_action    = ACT_EN;
          w_mindex    = r_mach;
          w_din       = {28'h0, r_en};
          w_en_issued = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched load parameters (captured on an accepted start)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mach       <= 2'd0;
      r_start_addr <= 5'd0;
      r_prog_len   <= 6'd0;
      r_pins       <= 32'd0;
      r_div        <= 24'd0;
      r_side       <= 5'd0;
      r_jmp        <= 4'd0;
      r_en         <= 4'd0;
    end else if (w_latch) begin
      r_mach       <= mach;
      r_start_addr <= start_addr;
      r_prog_len   <= prog_len;
      r_pins       <= pins_cfg;
      r_div        <= div_cfg;
      r_side       <= side_cfg;
      r_jmp        <= jmp_cfg;
      r_en         <= en_cfg;
    end
  end

  // ---------------------------------------------------------------------------
  // Write address, remaining-word count and stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= 5'd0;
      r_left <= 6'd0;
    end else if (w_latch) begin
      r_addr <= start_addr;
      r_left <= prog_len;
    end else if (w_word) begin
      r_addr <= r_addr + 5'd1;
      r_left <= r_left - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (w_to_clr) begin
      r_to_cnt <= '0;
    end else if (w_to_inc) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command and status output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_action    <= ACT_NOP;
      r_index     <= 5'd0;
      r_mindex    <= 2'd0;
      r_din       <= 32'd0;
      r_err       <= 1'b0;
      r_en_issued <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_action    <= w_action;
      r_index     <= w_index;
      r_mindex    <= w_mindex;
      r_din       <= w_din;
      r_err       <= w_err;
      // done trails the EN command by one cycle, so it lands after EN has
      // been presented and while the FSM already reports idle.
      r_en_issued <= w_en_issued;
      r_done      <= r_en_issued;
    end
  end

  assign action      = r_action;
  assign index       = r_index;
  assign mindex      = r_mindex;
  assign din         = r_din;
  assign err         = r_err;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign s_ready     = w_s_ready;
  assign h_ready     = w_h_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pio_loader.sv
// -----------------------------------------------------------------------------
// tb_pio_loader
// Directed testbench for pio_loader (TIMEOUT=4). Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, i.e. they reflect the
// edge just taken. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pio_loader;
  import pio_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT stimulus
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   mach = 2'd0;
  logic [4:0]   start_addr = 5'd0;
  logic [5:0]   prog_len = 6'd0;
  logic [31:0]  pins_cfg = 32'd0;
  logic [23:0]  div_cfg = 24'd0;
  logic [4:0]   side_cfg = 5'd0;
  logic [3:0]   jmp_cfg = 4'd0;
  logic [3:0]   en_cfg = 4'd0;
  logic         s_valid = 1'b0;
  logic [15:0]  s_data = 16'd0;
  logic         h_valid = 1'b0;
  logic [3:0]   h_action = 4'd0;
  logic [4:0]   h_index = 5'd0;
  logic [1:0]   h_mindex = 2'd0;
  logic [31:0]  h_din = 32'd0;

  // DUT observation
  logic         s_ready;
  logic         h_ready;
  logic [3:0]   action;
  logic [4:0]   index;
  logic [1:0]   mindex;
  logic [31:0]  din;
  logic         busy;
  logic         done;
  logic         err;
  state_t       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  pio_loader #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mach(mach), .start_addr(start_addr), .prog_len(prog_len),
    .pins_cfg(pins_cfg), .div_cfg(div_cfg), .side_cfg(side_cfg),
    .jmp_cfg(jmp_cfg), .en_cfg(en_cfg),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .h_valid(h_valid), .h_action(h_action), .h_index(h_index),
    .h_mindex(h_mindex), .h_din(h_din), .h_ready(h_ready),
    .action(action), .index(index), .mindex(mindex), .din(din),
    .busy(busy), .done(done), .err(err), .o_dbg_state(dbg_state)
  );

  // Driver: advance one clock, land 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full command word check: action, index, mindex, din
  task automatic chk_cmd(input string tag, input logic [3:0] a, input logic [4:0] i,
                         input logic [1:0] m, input logic [31:0] d);
    chk({tag, ".action"}, {28'h0, action}, {28'h0, a});
    chk({tag, ".index"},  {27'h0, index},  {27'h0, i});
    chk({tag, ".mindex"}, {30'h0, mindex}, {30'h0, m});
    chk({tag, ".din"},    din, d);
  endtask

  task automatic start_load(input logic [1:0] m, input logic [4:0] a, input logic [5:0] l);
    mach = m; start_addr = a; prog_len = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1;
    chk("rst.h_ready", {31'h0, h_ready}, 32'd0);
    chk("rst.s_ready", {31'h0, s_ready}, 32'd0);
    chk("rst.busy",    {31'h0, busy},    32'd0);
    chk_cmd("rst", 4'd0, 5'd0, 2'd0, 32'd0);
    step(); step();
    reset = 1'b0;
    step();
    chk("idle.h_ready", {31'h0, h_ready}, 32'd1);

    // ---------------- normal load, with same-cycle host command ----------------
    pins_cfg = 32'h1234_5678; div_cfg = 24'hABCDEF; side_cfg = 5'h15;
    jmp_cfg = 4'h9; en_cfg = 4'h5;
    mach = 2'd2; start_addr = 5'd4; prog_len = 6'd3; start = 1'b1;
    h_valid = 1'b1; h_action = 4'd3; h_index = 5'd9; h_mindex = 2'd1; h_din = 32'h5555_AAAA;
    #1;
    chk("start_vs_host.h_ready", {31'h0, h_ready}, 32'd0);
    step();
    start = 1'b0; h_valid = 1'b0;
    chk_cmd("start_vs_host.no_fwd", 4'd0, 5'd0, 2'd0, 32'd0);
    chk("load.busy",    {31'h0, busy},    32'd1);
    chk("load.s_ready", {31'h0, s_ready}, 32'd1);
    chk("load.state",   {29'h0, dbg_state}, {29'h0, ST_LOAD});

    // A start while busy must not disturb the sequence
    start = 1'b1; start_addr = 5'd20; mach = 2'd1;
    s_valid = 1'b1; s_data = 16'hA001;
    step();
    start = 1'b0;
    chk_cmd("w0", 4'd1, 5'd4, 2'd2, 32'h0000_A001);
    s_data = 16'hA002;
    step();
    chk_cmd("w1", 4'd1, 5'd5, 2'd2, 32'h0000_A002);
    s_data = 16'hA003;
    step();
    s_valid = 1'b0;
    chk_cmd("w2", 4'd1, 5'd6, 2'd2, 32'h0000_A003);
    chk("w2.s_ready_drops", {31'h0, s_ready}, 32'd0);
    step();
    chk_cmd("pend", 4'd2, 5'd6, 2'd2, 32'd0);
    step();
    chk_cmd("pins", 4'd5, 5'd0, 2'd2, 32'h1234_5678);
    step();
    chk_cmd("div", 4'd7, 5'd0, 2'd2, 32'h00AB_CDEF);
    step();
    chk_cmd("side", 4'd8, 5'd0, 2'd2, 32'h0000_0015);
    step();
    chk_cmd("jmp", 4'd10, 5'd0, 2'd2, 32'h0000_0009);
    step();
    chk_cmd("en", 4'd6, 5'd0, 2'd2, 32'h0000_0005);
    chk("en.done_not_yet", {31'h0, done}, 32'd0);
    step();
    chk("done.pulse", {31'h0, done}, 32'd1);
    chk("done.busy",  {31'h0, busy}, 32'd0);
    chk_cmd("done.nop", 4'd0, 5'd0, 2'd0, 32'd0);
    step();
    chk("done.one_cycle", {31'h0, done}, 32'd0);

    // ---------------- out-of-range start ----------------
    start_load(2'd1, 5'd30, 6'd3);
    chk("range.err",  {31'h0, err},  32'd1);
    chk("range.busy", {31'h0, busy}, 32'd0);
    chk_cmd("range.nop", 4'd0, 5'd0, 2'd0, 32'd0);
    step();
    chk("range.err_one_cycle", {31'h0, err}, 32'd0);
    chk("range.action_idle", {28'h0, action}, 32'd0);

    // Zero-length start
    start_load(2'd0, 5'd0, 6'd0);
    chk("len0.err",  {31'h0, err},  32'd1);
    chk("len0.busy", {31'h0, busy}, 32'd0);
    step();

    // ---------------- host command forwarding ----------------
    h_valid = 1'b1; h_action = 4'd4; h_index = 5'd7; h_mindex = 2'd1; h_din = 32'hDEAD_BEEF;
    #1;
    chk("host.h_ready", {31'h0, h_ready}, 32'd1);
    step();
    h_valid = 1'b0;
    chk_cmd("host.fwd", 4'd4, 5'd7, 2'd1, 32'hDEAD_BEEF);
    step();
    chk_cmd("host.one_cycle", 4'd0, 5'd0, 2'd0, 32'd0);

    // ---------------- stream timeout (TIMEOUT=4) ----------------
    start_load(2'd3, 5'd0, 6'd4);
    s_valid = 1'b1; s_data = 16'h1111;
    step();
    s_valid = 1'b0;
    chk_cmd("to.w0", 4'd1, 5'd0, 2'd3, 32'h0000_1111);
    step(); step(); step();
    chk("to.stall3.busy", {31'h0, busy}, 32'd1);
    chk("to.stall3.err",  {31'h0, err},  32'd0);
    step();
    chk("to.err",  {31'h0, err},  32'd1);
    chk("to.busy", {31'h0, busy}, 32'd0);
    chk("to.action", {28'h0, action}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("to.no_cmd", {28'h0, action}, 32'd0);
    end

    // ---------------- abort during DIV ----------------
    start_load(2'd1, 5'd8, 6'd1);
    s_valid = 1'b1; s_data = 16'h2222;
    step();
    s_valid = 1'b0;
    chk_cmd("ab.w0", 4'd1, 5'd8, 2'd1, 32'h0000_2222);
    step();
    chk_cmd("ab.pend", 4'd2, 5'd8, 2'd1, 32'd0);
    step();
    chk_cmd("ab.pins", 4'd5, 5'd0, 2'd1, 32'h1234_5678);
    chk("ab.in_div", {29'h0, dbg_state}, {29'h0, ST_DIV});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_cmd("ab.nop", 4'd0, 5'd0, 2'd0, 32'd0);
    chk("ab.busy", {31'h0, busy}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ab.quiet", {26'h0, action, err, done}, 32'd0);
    end

    // ---------------- reset during LOAD ----------------
    start_load(2'd2, 5'd10, 6'd5);
    s_valid = 1'b1; s_data = 16'h3333;
    step();
    chk_cmd("rl.w0", 4'd1, 5'd10, 2'd2, 32'h0000_3333);
    reset = 1'b1;
    #1;
    chk_cmd("rl.async", 4'd0, 5'd0, 2'd0, 32'd0);
    chk("rl.busy",    {31'h0, busy},    32'd0);
    chk("rl.s_ready", {31'h0, s_ready}, 32'd0);
    chk("rl.h_ready", {31'h0, h_ready}, 32'd0);
    s_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rl.no_enable", {26'h0, action, err, done}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pio_loader.md
PIO_LOADER -- requirements
Module: pio_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: consecutive stalled stream cycles in LOAD before abort with error.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports start (input, 1, begin load sequence) and abort (input, 1, synchronous cancel).
REQ-005 SHALL have ports mach (input, 2, target machine), start_addr (input, 5, first instruction index) and prog_len (input, 6, word count, 1..32).
REQ-006 SHALL have config inputs pins_cfg (32, pin-group word), div_cfg (24, clock divider), side_cfg (5, sideset bits), jmp_cfg (4, jump pins) and en_cfg (4, enable mask).
REQ-007 SHALL have stream ports s_valid (input, 1), s_data (input, 16, instruction word) and s_ready (output, 1).
REQ-008 SHALL have host ports h_valid (input, 1), h_action (input, 4), h_index (input, 5), h_mindex (input, 2), h_din (input, 32) and h_ready (output, 1).
REQ-009 SHALL have PIO command outputs action (4), index (5), mindex (2) and din (32), all registered.
REQ-010 SHALL have status outputs busy (1), done (1, one-cycle pulse) and err (1, one-cycle pulse).

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, PEND, PINS, DIV, SIDE, JMP, EN; busy = (state != IDLE).
REQ-012 SHALL in IDLE, when start=1, latch mach, start_addr, prog_len and all *_cfg inputs, then enter LOAD.
REQ-013 SHALL on start with prog_len=0 or start_addr+prog_len>32 pulse err next cycle, issue no command and stay in IDLE.
REQ-014 SHALL assert s_ready only in LOAD; each accepted word (s_valid&s_ready at cycle N) SHALL produce action=1, index=addr, din={16'h0,s_data} at cycle N+1, then increment addr; throughput 1 word/cycle.
REQ-015 SHALL after the last word (write cycle L) emit one command per cycle: L+1 action=2, index=start_addr+prog_len-1; L+2 action=5, din=pins_cfg; L+3 action=7, din={8'h0,div_cfg}; L+4 action=8, din={27'h0,side_cfg}; L+5 action=10, din={28'h0,jmp_cfg}; L+6 action=6, din={28'h0,en_cfg}.
REQ-016 SHALL drive mindex=latched mach on every loader command and pulse done at L+7 with state=IDLE.
REQ-017 SHALL drive action=0, index=0, mindex=0, din=0 in every cycle with no command, so that each command lasts exactly one cycle.
REQ-018 SHALL count consecutive LOAD cycles with s_valid=0, reset the count on accept, and on reaching TIMEOUT pulse err, go to IDLE and issue no further commands.
REQ-019 SHALL on abort=1 in any busy state go to IDLE next cycle with action=0 and no done or err; abort in IDLE is ignored.
REQ-020 SHALL drive h_ready = (state==IDLE) & ~start; start has priority over a same-cycle host command.
REQ-021 SHALL forward an accepted host command (cycle N) to action/index/mindex/din unchanged at N+1 for exactly one cycle.
REQ-022 SHALL ignore start while busy.

Reset
REQ-023 SHALL on reset force state=IDLE, clear the addr and timeout counters, and set all outputs to 0: action, index, mindex, din, s_ready, busy, done, err, and h_ready while reset is asserted.
REQ-024 SHALL not issue an enable command after reset mid-sequence; the partially loaded program is left unenabled.

Structure
REQ-025 SHALL take action codes (NOP=0, INSTR=1, PEND=2, PULL=3, PUSH=4, PINS=5, EN=6, DIV=7, SIDE=8, IMM=9, JMPPIN=10) and the FSM state enum from shared package pio_pkg.
REQ-026 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-027 SHALL cover: mach=2, start_addr=4, prog_len=3, words A001/A002/A003, no stalls -> three action=1 writes at index 4,5,6; then action=2 with index=6, then 5,7,8,10,6 on consecutive cycles; done one cycle after action=6.
REQ-028 SHALL cover: start_addr=30, prog_len=3 -> err pulse, no nonzero action.
REQ-029 SHALL cover: TIMEOUT=4, s_valid low 4 cycles after the first word -> err, IDLE, no action=6.
REQ-030 SHALL cover: start and h_valid in the same IDLE cycle -> h_ready=0, host command not forwarded; in IDLE, h_action=4 with h_din=0xDEADBEEF -> action=4, din=0xDEADBEEF for one cycle.
REQ-031 SHALL cover: abort during DIV -> no SIDE, JMP or EN command, no done; reset asserted during LOAD -> outputs 0 immediately.
